// File: rtl/mul_pkg.sv
// Shared types and widths for the multiply functional-unit controller.
//   MUL_TAG_W : reservation-station tag width carried in the payload structs
//   mul_op_t  : per-stage control {valid, tag, hi}
//   mul_res_t : result-buffer entry {tag, data}
package mul_pkg;

    localparam int unsigned MUL_TAG_W = 4;
    localparam int unsigned DATA_W    = 32;

    typedef struct packed {
        logic                 valid;
        logic [MUL_TAG_W-1:0] tag;
        logic                 hi;
    } mul_op_t;

    typedef struct packed {
        logic [MUL_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    data;
    } mul_res_t;

    // Pick the requested 32-bit half of a 64-bit product.
    function automatic logic [DATA_W-1:0] sel_half(input logic [2*DATA_W-1:0] p,
                                                   input logic hi);
        return hi ? p[2*DATA_W-1:DATA_W] : p[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mul_rq_fifo.sv
// Result buffer: synchronous FIFO of mul_res_t with flush and combinational head.
//   clk_i, rst_i : clock, synchronous active-high reset (also clears storage)
//   flush_i      : empty the FIFO at this edge
//   wr_en_i/wr_data_i : push
//   rd_en_i      : pop head (ignored when empty)
//   head_o       : current head, zero when empty
//   full_o, empty_o : occupancy flags
module mul_rq_fifo
    import mul_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     flush_i,
    input  logic     wr_en_i,
    input  mul_res_t wr_data_i,
    input  logic     rd_en_i,
    output mul_res_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    mul_res_t        mem_q [DEPTH];
    logic [IW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            do_wr, do_rd;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign do_wr   = wr_en_i;
    assign do_rd   = rd_en_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_wr && !do_rd)      cnt_q <= cnt_q + CW'(1);
            else if (do_rd && !do_wr) cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/mul_wallace32.sv
// 32x32 unsigned multiplier datapath (CSA tree plus final adder), purely
// combinational; the multiply operator maps onto the tree in synthesis.
//   a_i, b_i : unsigned operands
//   p_o      : 64-bit product
module mul_wallace32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o
);

    assign p_o = 64'(a_i) * 64'(b_i);

endmodule

// File: rtl/mul_fu_ctrl.sv
// Multiply functional-unit controller: credit-gated issue into a fixed-latency
// multiply pipeline, results buffered in order for the CDB arbiter.
//   iss_*   : issue handshake from the multiply reservation stations
//   cdb_*   : result-buffer head offered to the CDB arbiter
//   flush   : squash all in-flight and buffered ops
//   busy    : any op in the pipeline or buffer
module mul_fu_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned LAT      = 3,
    parameter int unsigned RQ_DEPTH = 4,
    parameter int unsigned TAG_W    = MUL_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [TAG_W-1:0] iss_tag,
    input  logic [31:0]      iss_a,
    input  logic [31:0]      iss_b,
    input  logic             iss_hi,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data,
    input  logic             flush,
    output logic             busy
);

    localparam int unsigned CRED_W = $clog2(RQ_DEPTH + 1);

    logic [CRED_W-1:0] cred_q, cred_d;
    logic              accept, pop;
    logic [31:0]       a_q, b_q;
    mul_op_t           op1_q;
    logic [63:0]       prod;
    mul_op_t           last_op;
    logic [63:0]       last_prod;
    logic              pipe_busy;
    mul_res_t          wr_res, head;
    logic              fifo_full, fifo_empty;

    assign iss_ready = (cred_q != '0) && !flush;
    assign accept    = iss_valid && iss_ready;
    assign cdb_req   = !fifo_empty && !flush;
    assign pop       = cdb_req && cdb_grant;

    // Credits count free slots across pipeline and buffer together.
    always_comb begin
        cred_d = cred_q;
        if (accept && !pop)      cred_d = cred_q - CRED_W'(1);
        else if (pop && !accept) cred_d = cred_q + CRED_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) cred_q <= CRED_W'(RQ_DEPTH);
        else              cred_q <= cred_d;
    end

    // Stage s1: operands and control; accept is already low during flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op1_q <= '0;
        end else begin
            op1_q.valid <= accept;
            if (accept) begin
                a_q       <= iss_a;
                b_q       <= iss_b;
                op1_q.tag <= MUL_TAG_W'(iss_tag);
                op1_q.hi  <= iss_hi;
            end
        end
    end

    mul_wallace32 u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    // Stages s2..sLAT carry product and control side by side.
    if (LAT == 1) begin : g_lat1
        assign last_op   = op1_q;
        assign last_prod = prod;
        assign pipe_busy = 1'b0;
    end else begin : g_pipe
        mul_op_t     op_q   [LAT-1];
        logic [63:0] prod_q [LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < int'(LAT) - 1; k++) begin
                    op_q[k]   <= '0;
                    prod_q[k] <= '0;
                end
            end else begin
                op_q[0]   <= op1_q;
                prod_q[0] <= prod;
                for (int k = 1; k < int'(LAT) - 1; k++) begin
                    op_q[k]   <= op_q[k-1];
                    prod_q[k] <= prod_q[k-1];
                end
                if (flush) begin
                    for (int k = 0; k < int'(LAT) - 1; k++) op_q[k].valid <= 1'b0;
                end
            end
        end

        always_comb begin
            pipe_busy = 1'b0;
            for (int k = 0; k < int'(LAT) - 1; k++) pipe_busy = pipe_busy | op_q[k].valid;
        end

        assign last_op   = op_q[LAT-2];
        assign last_prod = prod_q[LAT-2];
    end

    assign wr_res.tag  = last_op.tag;
    assign wr_res.data = sel_half(last_prod, last_op.hi);

    mul_rq_fifo #(.DEPTH(RQ_DEPTH)) u_rq (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush),
        .wr_en_i   (last_op.valid),
        .wr_data_i (wr_res),
        .rd_en_i   (pop),
        .head_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Credits make a write into a full buffer impossible.
    always_ff @(posedge clk) begin
        if (!rst && !flush && last_op.valid) assert (!fifo_full);
    end

    assign cdb_tag  = TAG_W'(head.tag);
    assign cdb_data = head.data;
    assign busy     = op1_q.valid || pipe_busy || !fifo_empty;

endmodule
